// File: rtl/wb_excp_commit.sv
// Writeback commit controller: drives the CSR file and exception/ERTN commit pulses, then issues a
// registered flush with redirect target and blocks commits for a fixed drain window.
module wb_excp_commit #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter logic [5:0]  ECODE_INT    = 6'h00
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_ex_in,
    input  logic [5:0]  wb_ecode_in,
    input  logic [8:0]  wb_esubcode_in,
    input  logic [31:0] wb_vaddr_in,
    input  logic        wb_ertn,
    input  logic [1:0]  wb_csr_op,
    input  logic [13:0] wb_csr_num,
    input  logic [31:0] wb_rd_val,
    input  logic [31:0] wb_rj_val,
    input  logic        has_int,
    input  logic [31:0] csr_rvalue,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ertn_entry,
    output logic        csr_re,
    output logic [13:0] csr_num,
    output logic        csr_we,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        wb_ex,
    output logic [31:0] wb_csr_pc,
    output logic [31:0] wb_vaddr,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic        ertn_flush,
    output logic        rf_commit,
    output logic [31:0] csr_result,
    output logic        flush_req,
    output logic [31:0] flush_target,
    output logic        commit_block
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        int_pend_q;
    logic        flush_req_q;
    logic [31:0] flush_target_q;

    logic commit;
    logic take_int;
    logic take_ex;
    logic take_ertn;
    logic csr_act;

    // Reset gating keeps every pulse low while resetn is asserted, even before the first edge.
    assign commit    = resetn && (state_q == ST_IDLE) && wb_valid;
    assign take_int  = commit && int_pend_q;
    assign take_ex   = commit && (int_pend_q || wb_ex_in);
    assign take_ertn = commit && !int_pend_q && !wb_ex_in && wb_ertn;
    assign csr_act   = commit && !int_pend_q && !wb_ex_in && !wb_ertn && (wb_csr_op != 2'b00);

    always_comb begin
        csr_re      = csr_act;
        csr_num     = csr_act ? wb_csr_num : 14'h0;
        csr_we      = csr_act && wb_csr_op[1];
        csr_wmask   = 32'h0;
        csr_wvalue  = 32'h0;
        if (csr_act && wb_csr_op[1]) begin
            csr_wmask  = wb_csr_op[0] ? wb_rj_val : 32'hFFFF_FFFF;
            csr_wvalue = wb_rd_val;
        end
        wb_ex       = take_ex;
        wb_csr_pc   = take_ex ? wb_pc : 32'h0;
        wb_vaddr    = (take_ex && !take_int) ? wb_vaddr_in : 32'h0;
        wb_ecode    = 6'h0;
        wb_esubcode = 9'h0;
        if (take_int) begin
            wb_ecode = ECODE_INT;
        end else if (take_ex) begin
            wb_ecode    = wb_ecode_in;
            wb_esubcode = wb_esubcode_in;
        end
        ertn_flush   = take_ertn;
        rf_commit    = commit && !take_ex && !take_ertn;
        csr_result   = csr_act ? csr_rvalue : 32'h0;
        flush_req    = flush_req_q;
        flush_target = flush_target_q;
        commit_block = (state_q != ST_IDLE);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (take_ex || take_ertn) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                state_d = ST_DRAIN;
                cnt_d   = 4'(DRAIN_CYCLES - 1);
            end
            ST_DRAIN: begin
                if (cnt_q == 4'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 4'd0;
            int_pend_q     <= 1'b0;
            flush_req_q    <= 1'b0;
            flush_target_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flush_req_q <= take_ex || take_ertn;
            if (take_ex)      int_pend_q <= 1'b0;
            else if (has_int) int_pend_q <= 1'b1;
            if (take_ex)        flush_target_q <= ex_entry;
            else if (take_ertn) flush_target_q <= ertn_entry;
        end
    end

endmodule
